fifo_stream_reader: RTL and testbench



---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 tb/tb_fifo_stream_reader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and word type for the synchronous FIFO and its stream reader.
package fifo_pkg;

  localparam int FIFO_BUF_DEPTH_MIN = 2;
  localparam int FIFO_BUF_DEPTH_MAX = 8;
  localparam int FIFO_DATA_WIDTH    = 8;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: absorbs its one-cycle read latency
// through a small circular prefetch buffer and presents the words as a valid/ready stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W1 = OCC_W + 1;
  localparam int IDX_W  = $clog2(BUF_DEPTH);

  localparam logic [OCC_W1-1:0] DEPTH_CREDIT = OCC_W1'(BUF_DEPTH);
  localparam logic [OCC_W-1:0]  DEPTH_OCC    = OCC_W'(BUF_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(BUF_DEPTH - 1);

  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_mem_q [BUF_DEPTH];

  logic              capture;
  logic              pop;
  logic [OCC_W1-1:0] credit;

  // A read is only issued when buffered plus in-flight words leave room, so m_ready never reaches fifo_r_en.
  always_comb begin
    credit    = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    fifo_r_en = rst_n && !flush && !fifo_empty && (credit < DEPTH_CREDIT);
    capture   = inflight_q && !flush;
    m_valid   = (occ_q != '0);
    m_data    = m_valid ? buf_mem_q[rd_idx_q] : '0;
    pop       = m_valid && m_ready;
    busy      = m_valid || inflight_q;
  end

  always_comb begin
    occ_d      = occ_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    inflight_d = fifo_r_en;
    if (flush) begin
      occ_d      = '0;
      wr_idx_d   = '0;
      rd_idx_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (capture) wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
      if (pop)     rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
      case ({capture, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      inflight_q <= inflight_d;
    end
  end

  // Data storage carries no reset; m_valid masks whatever it holds.
  always_ff @(posedge clk) begin
    if (capture) buf_mem_q[wr_idx_q] <= fifo_data;
  end

  a_depth_legal: assert property (@(posedge clk)
    (BUF_DEPTH >= FIFO_BUF_DEPTH_MIN) && (BUF_DEPTH <= FIFO_BUF_DEPTH_MAX));

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= DEPTH_OCC);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (occ_q == DEPTH_OCC) && !pop));

  a_stream_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized self-checking bench for fifo_stream_reader against a queue-based FIFO
// model and an in-order scoreboard of pushed words.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  fifo_word_t fifo_data;
  logic       fifo_r_en;
  logic       flush;
  logic       m_valid;
  fifo_word_t m_data;
  logic       m_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;

  fifo_word_t mem [4096];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  fifo_word_t pending_q[$];
  fifo_word_t exp_q[$];
  int         pops_total    = 0;
  int         dropped_total = 0;

  fifo_stream_reader #(.DATA_WIDTH(FIFO_DATA_WIDTH), .BUF_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .flush(flush), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with registered read data; reset discards its contents.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic tick(input logic rdy, input logic fl);
    fifo_word_t w;
    @(negedge clk);
    m_ready = rdy;
    flush   = fl;
    while (pending_q.size() != 0) begin
      w = pending_q.pop_front();
      mem[wr_ptr] = w;
      exp_q.push_back(w);
      wr_ptr++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0;
    pending_q.push_back(8'h5A);
    tick(1'b0, 1'b0);
    total += 4;
    if (fifo_r_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_ren: got %b expected 0", fifo_r_en); end
    if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (m_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %02h expected 00", m_data); end
    tick(1'b0, 1'b0);
    exp_q.delete();
    dropped_total = wr_ptr - pops_total;
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_valid: got %b expected 0", m_valid); end
  endtask

  task automatic test_basic();
    int first_ren = -1, first_valid = -1, first_pop = -1, last_pop = -1, n_pop = 0;
    fifo_word_t exp_w;
    pending_q.push_back(8'h11); pending_q.push_back(8'h22); pending_q.push_back(8'h33);
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, 1'b0);
      if (fifo_r_en && first_ren < 0) first_ren = c;
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w) begin bad++; $display("[TB] FAIL basic_data: got %02h expected %02h", m_data, exp_w); end
        pops_total++; n_pop++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
    end
    total += 5;
    if (first_ren != 0) begin bad++; $display("[TB] FAIL basic_ren_cycle: got %0d expected 0", first_ren); end
    if (first_valid != 2) begin bad++; $display("[TB] FAIL basic_latency: got %0d expected 2", first_valid); end
    if (n_pop != 3 || last_pop - first_pop != 2) begin bad++; $display("[TB] FAIL basic_consecutive: got %0d pops span %0d expected 3 pops span 2", n_pop, last_pop - first_pop); end
    if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle_valid: got %b expected 0", m_valid); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stream16();
    int first_pop = -1, last_pop = -1, n_pop = 0, empty_reads = 0;
    fifo_word_t exp_w;
    for (int i = 0; i < 16; i++) pending_q.push_back(fifo_word_t'($urandom));
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 1'b0);
      if (fifo_r_en && fifo_empty) empty_reads++;
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w) begin bad++; $display("[TB] FAIL stream16_data: got %02h expected %02h", m_data, exp_w); end
        pops_total++; n_pop++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
    end
    total += 3;
    if (n_pop != 16 || last_pop - first_pop != 15) begin bad++; $display("[TB] FAIL stream16_bubbles: got %0d pops span %0d expected 16 pops span 15", n_pop, last_pop - first_pop); end
    if (empty_reads != 0) begin bad++; $display("[TB] FAIL stream16_read_empty: got %0d expected 0", empty_reads); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stream16_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    fifo_word_t first_w, exp_w;
    for (int i = 0; i < 10; i++) pending_q.push_back(fifo_word_t'($urandom));
    first_w = pending_q[0];
    for (int c = 0; c < 14; c++) begin
      tick(1'b0, 1'b0);
      if (fifo_r_en) pulses++;
      if (m_valid) begin
        total++;
        if (m_data !== first_w) begin bad++; $display("[TB] FAIL stall_hold: got %02h expected %02h", m_data, first_w); end
      end
    end
    total += 2;
    if (pulses != 3) begin bad++; $display("[TB] FAIL stall_pulses: got %0d expected 3", pulses); end
    if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid: got %b expected 1", m_valid); end
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      tick(1'b1, 1'b0);
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w) begin bad++; $display("[TB] FAIL stall_drain_data: got %02h expected %02h", m_data, exp_w); end
        pops_total++;
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL stall_drain_done: got %0d left expected 0", exp_q.size()); end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_toggle();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic prev_stall = 1'b0;
    fifo_word_t prev_data = '0, exp_w;
    int n_pop = 0;
    for (int i = 0; i < 8; i++) pending_q.push_back(fifo_word_t'(8'hA0 + i));
    for (int c = 0; c < 60; c++) begin
      tick(pat[c % 4], 1'b0);
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin bad++; $display("[TB] FAIL toggle_stable: got v=%b d=%02h expected v=1 d=%02h", m_valid, m_data, prev_data); end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w) begin bad++; $display("[TB] FAIL toggle_data: got %02h expected %02h", m_data, exp_w); end
        pops_total++; n_pop++;
      end
    end
    total++;
    if (n_pop != 8) begin bad++; $display("[TB] FAIL toggle_count: got %0d expected 8", n_pop); end
  endtask

  task automatic test_flush();
    int pulses = 0, lost;
    fifo_word_t fourth_w, exp_w;
    logic seen_first = 1'b0;
    for (int i = 0; i < 4; i++) pending_q.push_back(fifo_word_t'($urandom));
    fourth_w = pending_q[3];
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0);
      if (fifo_r_en) pulses++;
    end
    tick(1'b0, 1'b1);
    total += 3;
    if (pulses != 3) begin bad++; $display("[TB] FAIL flush_pulses: got %0d expected 3", pulses); end
    if (fifo_r_en !== 1'b0) begin bad++; $display("[TB] FAIL flush_ren: got %b expected 0", fifo_r_en); end
    if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_valid: got %b expected 1", m_valid); end
    tick(1'b0, 1'b0);
    total += 2;
    if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b expected 0", m_valid); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    lost = rd_ptr - pops_total - dropped_total;
    for (int i = 0; i < lost && exp_q.size() != 0; i++) void'(exp_q.pop_front());
    dropped_total += lost;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      tick(1'b1, 1'b0);
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w || (!seen_first && m_data !== fourth_w)) begin bad++; $display("[TB] FAIL flush_next_data: got %02h expected %02h", m_data, exp_w); end
        seen_first = 1'b1;
        pops_total++;
      end
    end
    total++;
    if (!seen_first || exp_q.size() != 0) begin bad++; $display("[TB] FAIL flush_drain_done: got %0d left expected 0", exp_q.size()); end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    fifo_word_t exp_w;
    for (int i = 0; i < 5; i++) pending_q.push_back(fifo_word_t'($urandom));
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0);
    total++;
    if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_pre_valid: got %b expected 1", m_valid); end
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %b expected 0", m_valid); end
    if (fifo_r_en !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ren: got %b expected 0", fifo_r_en); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    exp_q.delete();
    dropped_total = wr_ptr - pops_total;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 1'b0);
      if (m_valid) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("[TB] FAIL rstmid_stale: got %0d expected 0", stale); end
    for (int i = 0; i < 3; i++) pending_q.push_back(fifo_word_t'($urandom));
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0);
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w) begin bad++; $display("[TB] FAIL rstmid_after_data: got %02h expected %02h", m_data, exp_w); end
        pops_total++;
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rstmid_drain_done: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int pushed = 0, empty_reads = 0;
    logic prev_stall = 1'b0;
    fifo_word_t prev_data = '0, exp_w;
    for (int c = 0; c < 400 && (pushed < 30 || exp_q.size() != 0 || pending_q.size() != 0); c++) begin
      if (pushed < 30 && $urandom_range(0, 2) == 0) begin
        for (int k = $urandom_range(1, 3); k > 0 && pushed < 30; k--) begin
          pending_q.push_back(fifo_word_t'($urandom));
          pushed++;
        end
      end
      tick(($urandom_range(0, 3) != 0), 1'b0);
      if (fifo_r_en && fifo_empty) empty_reads++;
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin bad++; $display("[TB] FAIL random_stable: got v=%b d=%02h expected v=1 d=%02h", m_valid, m_data, prev_data); end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (m_data !== exp_w) begin bad++; $display("[TB] FAIL random_data: got %02h expected %02h", m_data, exp_w); end
        pops_total++;
      end
    end
    total += 2;
    if (exp_q.size() != 0 || pushed != 30) begin bad++; $display("[TB] FAIL random_drain_done: got %0d left expected 0", exp_q.size()); end
    if (empty_reads != 0) begin bad++; $display("[TB] FAIL random_read_empty: got %0d expected 0", empty_reads); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream16();
    test_stall();
    test_toggle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
